// File: rtl/szcv_flag_unit.sv
// Architectural S/Z/C/V flag register and conditional-branch resolver.
// Branch results are registered and returned to fetch one cycle later.
module szcv_flag_unit #(
  parameter int DATA_W = 16,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  input  logic [1:0]        szcv_src,
  input  logic [3:0]        alu_szcv,
  input  logic [DATA_W-1:0] wdata,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_req,
  input  logic [2:0]        br_cond,
  output logic [3:0]        szcv,
  output logic              br_valid,
  output logic              br_taken,
  output logic [2:0]        br_cond_q
);

  logic [3:0] szcv_q, szcv_d;
  logic       br_valid_q, br_valid_d;
  logic       br_taken_q, br_taken_d;
  logic [2:0] br_cond_qq, br_cond_d;
  logic       commit, capture;
  logic [3:0] ef;
  logic       s_f, z_f, v_f, take;

  assign commit  = upd_valid & ~stall & ~flush;
  assign capture = br_req & ~stall & ~flush;

  always_comb begin
    szcv_d = szcv_q;
    if (commit) begin
      case (szcv_src)
        2'b00:   szcv_d = alu_szcv;
        2'b01:   szcv_d = {wdata[DATA_W-1], (wdata == '0), 2'b00};
        default: szcv_d = szcv_q;
      endcase
    end
  end

  // With forwarding, a same-cycle query sees the flags being committed.
  assign ef  = FWD_EN ? szcv_d : szcv_q;
  assign s_f = ef[3];
  assign z_f = ef[2];
  assign v_f = ef[0];

  always_comb begin
    take = 1'b0;
    case (br_cond)
      3'b000:  take = z_f;
      3'b001:  take = s_f ^ v_f;
      3'b010:  take = z_f | (s_f ^ v_f);
      3'b011:  take = ~z_f;
      3'b100:  take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    br_valid_d = capture;
    br_taken_d = capture & take;
    br_cond_d  = capture ? br_cond : br_cond_qq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      szcv_q     <= 4'b0000;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
      br_cond_qq <= 3'b000;
    end else begin
      szcv_q     <= szcv_d;
      br_valid_q <= br_valid_d;
      br_taken_q <= br_taken_d;
      br_cond_qq <= br_cond_d;
    end
  end

  assign szcv      = szcv_q;
  assign br_valid  = br_valid_q;
  assign br_taken  = br_taken_q;
  assign br_cond_q = br_cond_qq;

endmodule

// File: tb/tb_szcv_flag_unit.sv
// Bench for szcv_flag_unit: one forwarding and one non-forwarding instance
// share stimulus; branch results are checked by queue-based monitors.
module tb_szcv_flag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic [1:0]  szcv_src;
  logic [3:0]  alu_szcv;
  logic [15:0] wdata;
  logic        stall, flush, br_req;
  logic [2:0]  br_cond;

  logic [3:0] f1, f0;
  logic       v1, v0, t1, t0;
  logic [2:0] c1, c0;

  int compared = 0;
  int failed   = 0;

  logic [3:0] q1[$];
  logic [3:0] q0[$];

  always #5 clk = ~clk;

  szcv_flag_unit #(.DATA_W(16), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .szcv_src(szcv_src),
    .alu_szcv(alu_szcv), .wdata(wdata), .stall(stall), .flush(flush),
    .br_req(br_req), .br_cond(br_cond), .szcv(f1), .br_valid(v1),
    .br_taken(t1), .br_cond_q(c1)
  );

  szcv_flag_unit #(.DATA_W(16), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .szcv_src(szcv_src),
    .alu_szcv(alu_szcv), .wdata(wdata), .stall(stall), .flush(flush),
    .br_req(br_req), .br_cond(br_cond), .szcv(f0), .br_valid(v0),
    .br_taken(t0), .br_cond_q(c0)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (v1) begin
        if (q1.size() == 0) chk("fwd unexpected br_valid", 8'd1, 8'd0);
        else chk("fwd branch {taken,cond}", {4'd0, t1, c1}, {4'd0, q1.pop_front()});
      end else begin
        chk("fwd idle br_taken", {7'd0, t1}, 8'd0);
      end
      if (v0) begin
        if (q0.size() == 0) chk("nofwd unexpected br_valid", 8'd1, 8'd0);
        else chk("nofwd branch {taken,cond}", {4'd0, t0, c0}, {4'd0, q0.pop_front()});
      end else begin
        chk("nofwd idle br_taken", {7'd0, t0}, 8'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_valid = 1'b0; br_req = 1'b0; stall = 1'b0; flush = 1'b0;
    szcv_src = 2'b00; alu_szcv = 4'b0000; wdata = 16'h0000; br_cond = 3'b000;
  endtask

  task automatic flags(input string nm, input logic [3:0] exp);
    chk({nm, " fwd szcv"},   {4'd0, f1}, {4'd0, exp});
    chk({nm, " nofwd szcv"}, {4'd0, f0}, {4'd0, exp});
  endtask

  task automatic load_alu(input logic [3:0] v);
    upd_valid = 1'b1; szcv_src = 2'b00; alu_szcv = v;
    tick();
    idle();
  endtask

  task automatic query(input logic [2:0] cond, input logic exp1,
                       input logic exp0);
    br_req = 1'b1; br_cond = cond;
    q1.push_back({exp1, cond});
    q0.push_back({exp0, cond});
  endtask

  initial begin
    idle();
    rst = 1'b1;
    upd_valid = 1'b1; szcv_src = 2'b00; alu_szcv = 4'b1010;
    tick();
    tick();
    flags("in reset", 4'b0000);
    chk("in reset br_valid", {6'd0, v1, v0}, 8'd0);
    chk("in reset br_cond_q", {2'd0, c1, c0}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    flags("first commit", 4'b1010);
    idle();

    load_alu(4'b1111);
    upd_valid = 1'b1; szcv_src = 2'b01; wdata = 16'h8000;
    tick();
    flags("data negative", 4'b1000);
    wdata = 16'h0000;
    tick();
    flags("data zero", 4'b0100);
    idle();

    load_alu(4'b0110);
    upd_valid = 1'b1; szcv_src = 2'b11; alu_szcv = 4'b1001;
    tick();
    flags("hold src11", 4'b0110);
    szcv_src = 2'b10;
    tick();
    flags("reserved src10", 4'b0110);
    idle();

    load_alu(4'b0000);
    upd_valid = 1'b1; szcv_src = 2'b00; alu_szcv = 4'b0100;
    query(3'b000, 1'b1, 1'b0);
    tick();
    idle();
    flags("after fwd update", 4'b0100);
    query(3'b000, 1'b1, 1'b1);
    tick();
    idle();

    load_alu(4'b1000);
    query(3'b000, 1'b0, 1'b0); tick();
    query(3'b001, 1'b1, 1'b1); tick();
    query(3'b010, 1'b1, 1'b1); tick();
    query(3'b011, 1'b1, 1'b1); tick();
    query(3'b100, 1'b1, 1'b1); tick();
    query(3'b101, 1'b0, 1'b0); tick();
    query(3'b111, 1'b0, 1'b0); tick();
    idle();
    tick();

    upd_valid = 1'b1; alu_szcv = 4'b0100; br_req = 1'b1; stall = 1'b1;
    tick();
    flags("stall", 4'b1000);
    chk("stall br_valid", {6'd0, v1, v0}, 8'd0);
    stall = 1'b0; flush = 1'b1;
    tick();
    flags("flush", 4'b1000);
    chk("flush br_valid", {6'd0, v1, v0}, 8'd0);
    stall = 1'b1;
    tick();
    flags("stall+flush", 4'b1000);
    chk("stall+flush br_valid", {6'd0, v1, v0}, 8'd0);
    idle();

    query(3'b100, 1'b1, 1'b1);
    tick();
    idle();
    chk("pre-reset br_valid", {6'd0, v1, v0}, 8'd3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    flags("async reset", 4'b0000);
    chk("async reset br_valid", {6'd0, v1, v0}, 8'd0);
    chk("async reset br_taken", {6'd0, t1, t0}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk("queues drained", q1.size() + q0.size(), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
